// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// inst_fetch : PC / fetch register stage feeding decode from a combinational ROM
// Revision   : 1.0
// ============================================================================
module inst_fetch #(
   parameter int unsigned          ADDR_W     = 8,
   parameter int unsigned          INST_W     = 8,
   parameter logic [ADDR_W-1:0]    START_ADDR = '0,
   parameter logic [INST_W-1:0]    HALT_INST  = '1,
   parameter int unsigned          CNT_W      = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   output logic [ADDR_W-1:0] rom_address_o,
   input  logic [INST_W-1:0] rom_instruction_i,
   output logic [INST_W-1:0] instruction_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              valid_o,
   input  logic              ready_i,
   input  logic              branch_taken_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic              halted_o,
   output logic [CNT_W-1:0]  fetch_count_o
);

   localparam logic [ADDR_W-1:0] C_PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [INST_W-1:0]   ir_q, ir_d;
   logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
   logic                valid_q, valid_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                w_adv;
   logic                w_deliver;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= RUN;
         pc_q    <= START_ADDR;
         ir_q    <= '0;
         ir_pc_q <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ir_pc_q <= ir_pc_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign w_adv     = (state_q == RUN) && (!valid_q || ready_i);
   assign w_deliver = valid_q && ready_i;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      ir_pc_d = ir_pc_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;

      if (w_deliver && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + C_CNT_ONE;
      end

      if (state_q == RUN) begin
         // A redirect squashes both the held IR and this cycle's ROM word,
         // so it takes priority over a halt word arriving in the same cycle.
         if (branch_taken_i) begin
            pc_d    = branch_target_i;
            valid_d = 1'b0;
         end else if (w_adv) begin
            if (rom_instruction_i != HALT_INST) begin
               ir_d    = rom_instruction_i;
               ir_pc_d = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + C_PC_ONE;
            end else begin
               valid_d = 1'b0;
               state_d = HALT;
            end
         end
      end
   end

   assign rom_address_o = pc_q;
   assign instruction_o = ir_q;
   assign pc_o          = ir_pc_q;
   assign valid_o       = valid_q;
   assign halted_o      = (state_q == HALT);
   assign fetch_count_o = cnt_q;

endmodule
`default_nettype wire
